kempston_mouse: RTL and testbench

- Converts the hps_io PS/2 mouse packet bus into Kempston mouse state for the TSConf core.
- State is an 8-bit wrapping X counter, an 8-bit wrapping Y counter and an active-low button byte.
- The tsconf I/O read mux consumes the result through a registered Z80 port-read interface (#FBDF X, #FFDF Y, #FADF buttons).
- Sits between hps_io ps2_mouse and tsconf's port decoder.

---
 rtl/kempston_mouse.sv | 177 +++++++++++++++++
 tb/tb_kempston_mouse.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kempston_mouse.sv
// kempston_mouse
// ----------------------------------------------------------------------------
// Turns the hps_io PS/2 mouse packet bus into Kempston mouse state (wrapping
// X/Y counters and an active-low button byte). The state is read by the Z80
// through ports #FBDF (X), #FFDF (Y) and #FADF (buttons).
//
// Parameters:
//   DIV_SHIFT  movement divisor 2^DIV_SHIFT (0..3); the fractional remainder
//              is carried from one packet to the next
//   SWAP_BTN   1 = exchange left and right buttons
//
// Build option:
//   KMOUSE_ACCEL_EN  when defined, non-overflow deltas with |delta| >= 16 are
//                    doubled before the divider. Undefined: deltas unscaled.
//
// Ports:
//   clk_sys     system clock
//   reset_n     synchronous active-low reset
//   ps2_mouse   [24] toggle strobe, [23:16] Y, [15:8] X, [7:0] status
//               (b0 L, b1 R, b2 M, b4 Xsign, b5 Ysign, b6 Xovf, b7 Yovf)
//   enable      1 = mouse active
//   io_addr     Z80 port address
//   io_rd       one-cycle port read strobe
//   io_dout     registered read data
//   io_hit      io_dout holds data for a decoded port (one-cycle pulse)
//   kmouse_x    X counter
//   kmouse_y    Y counter
//   kmouse_btn  {5'b11111, ~M, ~L, ~R}
//
// Strobe semantics: a packet arrives whenever ps2_mouse[24] differs from its
// value on the previous clock; there is no back-pressure, so one packet per
// cycle is accepted. A read is a single-cycle io_rd pulse answered exactly
// one cycle later by io_hit/io_dout; there is no ready/wait path.
// ----------------------------------------------------------------------------
module kempston_mouse #(
    parameter int DIV_SHIFT = 1,
    parameter bit SWAP_BTN  = 1'b0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [24:0] ps2_mouse,
    input  logic        enable,
    input  logic [15:0] io_addr,
    input  logic        io_rd,
    output logic [7:0]  io_dout,
    output logic        io_hit,
    output logic [7:0]  kmouse_x,
    output logic [7:0]  kmouse_y,
    output logic [7:0]  kmouse_btn
);

`ifdef KMOUSE_ACCEL_EN
    localparam int DW = 10;  // doubled 9-bit delta needs one more bit
`else
    localparam int DW = 9;
`endif

    // Remainder keeps the low DIV_SHIFT bits of the accumulator.
    localparam logic [2:0] REM_MASK = 3'((1 << DIV_SHIFT) - 1);

    logic                 old_toggle;
    logic                 new_pkt;
    logic                 s1_valid;
    logic signed [DW-1:0] s1_dx;
    logic signed [DW-1:0] s1_dy;
    logic [2:0]           s1_btn;   // {M, L, R}, active-high, after swap
    logic [2:0]           rem_x;
    logic [2:0]           rem_y;

    logic signed [11:0]   acc_x;
    logic signed [11:0]   acc_y;
    logic signed [11:0]   step_x;
    logic signed [11:0]   step_y;

    logic                 dec_hit;
    logic [7:0]           rd_sel;
    logic                 unused_bits;

    assign new_pkt = ps2_mouse[24] != old_toggle;

    // Overflowed axes contribute nothing; the 9-bit signed delta is {sign, mag}.
    function automatic logic signed [DW-1:0] latch_delta(
        input logic       sgn,
        input logic [7:0] mag,
        input logic       ovf
    );
        logic signed [8:0] d;
        d = {sgn, mag};
        if (ovf) begin
            return '0;
        end
`ifdef KMOUSE_ACCEL_EN
        if ((d >= 9'sd16) || (d <= -9'sd16)) begin
            return {d, 1'b0};
        end
        return {d[8], d};
`else
        return d;
`endif
    endfunction

    // Stage 1: capture the packet (old_toggle tracks the strobe even when
    // disabled so re-enabling never replays a stale packet).
    always_ff @(posedge clk_sys) begin
        old_toggle <= ps2_mouse[24];
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_dx    <= '0;
            s1_dy    <= '0;
            s1_btn   <= '0;
        end else begin
            s1_valid <= new_pkt && enable;
            if (new_pkt && enable) begin
                s1_dx  <= latch_delta(ps2_mouse[4], ps2_mouse[15:8],  ps2_mouse[6]);
                s1_dy  <= latch_delta(ps2_mouse[5], ps2_mouse[23:16], ps2_mouse[7]);
                s1_btn <= SWAP_BTN ? {ps2_mouse[2], ps2_mouse[1], ps2_mouse[0]}
                                   : {ps2_mouse[2], ps2_mouse[0], ps2_mouse[1]};
            end
        end
    end

    // Stage 2 arithmetic: floor division with carried non-negative remainder.
    always_comb begin
        acc_x  = {{(12 - DW){s1_dx[DW-1]}}, s1_dx} + {9'd0, rem_x};
        acc_y  = {{(12 - DW){s1_dy[DW-1]}}, s1_dy} + {9'd0, rem_y};
        step_x = acc_x >>> DIV_SHIFT;
        step_y = acc_y >>> DIV_SHIFT;
    end

    // Stage 2 update: counters and buttons change together so a reader
    // never sees a half-applied packet.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rem_x      <= '0;
            rem_y      <= '0;
            kmouse_x   <= 8'h00;
            kmouse_y   <= 8'h00;
            kmouse_btn <= 8'hFF;
        end else if (s1_valid) begin
            rem_x      <= acc_x[2:0] & REM_MASK;
            rem_y      <= acc_y[2:0] & REM_MASK;
            kmouse_x   <= kmouse_x + step_x[7:0];
            kmouse_y   <= kmouse_y + step_y[7:0];
            kmouse_btn <= {5'b11111, ~s1_btn};
        end
    end

    // Port decode: low byte #DF; A8 picks buttons vs axis, A10 picks X vs Y.
    always_comb begin
        dec_hit = io_addr[7:0] == 8'hDF;
        if (!io_addr[8]) begin
            rd_sel = kmouse_btn;
        end else if (!io_addr[10]) begin
            rd_sel = kmouse_x;
        end else begin
            rd_sel = kmouse_y;
        end
    end

    // Registered read: returns the value held before any same-cycle update.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            io_dout <= 8'hFF;
            io_hit  <= 1'b0;
        end else begin
            io_hit <= 1'b0;
            if (io_rd && dec_hit && enable) begin
                io_dout <= rd_sel;
                io_hit  <= 1'b1;
            end
        end
    end

    assign unused_bits = ^{ps2_mouse[3], io_addr[15:11], io_addr[9],
                           step_x[11:8], step_y[11:8]};

endmodule

// File: tb/tb_kempston_mouse.sv
module tb_kempston_mouse;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic             reset_n;
  logic [24:0]      ps2_mouse;
  logic             enable;
  logic [15:0]      io_addr;
  logic             io_rd;
  logic [1:0][7:0]  dout, kx, ky, kb;
  logic [1:0]       hit;
  logic             tog;

  int n_chk  = 0;
  int n_pass = 0;

  // dut0: divisor 1, normal buttons. dut1: divisor 2, swapped buttons.
  kempston_mouse #(.DIV_SHIFT(0), .SWAP_BTN(1'b0)) dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse), .enable(enable),
    .io_addr(io_addr), .io_rd(io_rd), .io_dout(dout[0]), .io_hit(hit[0]),
    .kmouse_x(kx[0]), .kmouse_y(ky[0]), .kmouse_btn(kb[0])
  );

  kempston_mouse #(.DIV_SHIFT(1), .SWAP_BTN(1'b1)) dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse), .enable(enable),
    .io_addr(io_addr), .io_rd(io_rd), .io_dout(dout[1]), .io_hit(hit[1]),
    .kmouse_x(kx[1]), .kmouse_y(ky[1]), .kmouse_btn(kb[1])
  );

  // ---------------- reference model ----------------
  // Each instance keeps the exact total displacement since reset; the
  // counter is floor(total / 2^div) mod 256. Visible state lags the logical
  // state by one edge (two edges after the strobe is sampled).
  int         sum_x[2], sum_y[2];
  logic [7:0] lbtn[2];
  logic [7:0] vx[2], vy[2], vb[2], edout[2];
  logic       ehit[2];
  logic       prev_tog;

  function automatic int div_of(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int delta(input logic sgn, input logic [7:0] mag, input logic ovf);
    int d;
    if (ovf) return 0;
    d = sgn ? int'(mag) - 256 : int'(mag);
`ifdef KMOUSE_ACCEL_EN
    if (d >= 16 || d <= -16) d = 2 * d;
`endif
    return d;
  endfunction

  function automatic logic [7:0] btn_of(input logic [7:0] st, input int i);
    logic l, r;
    l = (i == 1) ? st[1] : st[0];
    r = (i == 1) ? st[0] : st[1];
    return {5'b11111, ~st[2], ~l, ~r};
  endfunction

  function automatic logic [7:0] cnt(input int s, input int i);
    int q;
    q = s >>> div_of(i);
    return q[7:0];
  endfunction

  always @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        sum_x[i] <= 0;      sum_y[i] <= 0;   lbtn[i] <= 8'hFF;
        vx[i]    <= 8'h00;  vy[i]    <= 8'h00; vb[i] <= 8'hFF;
        edout[i] <= 8'hFF;  ehit[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (io_rd && io_addr[7:0] == 8'hDF && enable) begin
          ehit[i]  <= 1'b1;
          edout[i] <= !io_addr[8] ? vb[i] : (!io_addr[10] ? vx[i] : vy[i]);
        end else begin
          ehit[i] <= 1'b0;
        end
        vx[i] <= cnt(sum_x[i], i);
        vy[i] <= cnt(sum_y[i], i);
        vb[i] <= lbtn[i];
        if (ps2_mouse[24] != prev_tog && enable) begin
          sum_x[i] <= sum_x[i] + delta(ps2_mouse[4], ps2_mouse[15:8],  ps2_mouse[6]);
          sum_y[i] <= sum_y[i] + delta(ps2_mouse[5], ps2_mouse[23:16], ps2_mouse[7]);
          lbtn[i]  <= btn_of(ps2_mouse[7:0], i);
        end
      end
    end
    prev_tog <= ps2_mouse[24];
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mdl%0d_x", i),    kx[i],   vx[i]);
      chk($sformatf("mdl%0d_y", i),    ky[i],   vy[i]);
      chk($sformatf("mdl%0d_btn", i),  kb[i],   vb[i]);
      chk($sformatf("mdl%0d_hit", i),  {7'd0, hit[i]}, {7'd0, ehit[i]});
      chk($sformatf("mdl%0d_dout", i), dout[i], edout[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk_sys);
    check_model();
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] st);
    tog = ~tog;
    ps2_mouse = {tog, y, x, st};
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  // One read pulse on dut0; checks hit and data in the following cycle.
  task automatic rd(input string name, input logic [15:0] addr,
                    input logic exp_hit, input logic [7:0] exp_data);
    io_addr = addr;
    io_rd   = 1'b1;
    cyc();
    io_rd   = 1'b0;
    chk({name, "_hit"}, {7'd0, hit[0]}, {7'd0, exp_hit});
    if (exp_hit) chk({name, "_data"}, dout[0], exp_data);
    cyc();
    chk({name, "_hit_drop"}, {7'd0, hit[0]}, 8'h00);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] x, y, st;
    logic [7:0] ex, ey, eb;
  } vec_t;

  vec_t vt[11];

  initial begin
    reset_n = 1'b0; enable = 1'b1; tog = 1'b0; ps2_mouse = '0;
    io_addr = 16'h0000; io_rd = 1'b0;

    // Reset state and port reads.
    do_reset();
    chk("rst_x",   kx[0], 8'h00);
    chk("rst_y",   ky[0], 8'h00);
    chk("rst_btn", kb[0], 8'hFF);
    rd("rd_x",    16'hFBDF, 1'b1, 8'h00);
    rd("rd_y",    16'hFFDF, 1'b1, 8'h00);
    rd("rd_btn",  16'hFADF, 1'b1, 8'hFF);
    rd("rd_alias", 16'h12DF, 1'b1, 8'hFF);
    rd("rd_miss", 16'hFBDE, 1'b0, 8'h00);

    // Table of sequential packets on dut0 (divisor 1).
    vt[0]  = '{8'h05, 8'hFD, 8'h29, 8'h05, 8'hFD, 8'hFD};
    vt[1]  = '{8'hF9, 8'h00, 8'h18, 8'hFE, 8'hFD, 8'hFF};
    vt[2]  = '{8'h05, 8'h00, 8'h08, 8'h03, 8'hFD, 8'hFF};
    vt[3]  = '{8'hFC, 8'h00, 8'h18, 8'hFF, 8'hFD, 8'hFF};
    vt[4]  = '{8'hFF, 8'h02, 8'h48, 8'hFF, 8'hFF, 8'hFF};
    vt[5]  = '{8'h00, 8'h00, 8'h0A, 8'hFF, 8'hFF, 8'hFE};
    vt[6]  = '{8'h00, 8'h00, 8'h0C, 8'hFF, 8'hFF, 8'hFB};
    vt[7]  = '{8'h03, 8'h50, 8'h88, 8'h02, 8'hFF, 8'hFF};
`ifdef KMOUSE_ACCEL_EN
    vt[8]  = '{8'h14, 8'h00, 8'h08, 8'h2A, 8'hFF, 8'hFF};
    vt[9]  = '{8'h0F, 8'h00, 8'h08, 8'h39, 8'hFF, 8'hFF};
    vt[10] = '{8'h00, 8'hEC, 8'h28, 8'h39, 8'hD7, 8'hFF};
`else
    vt[8]  = '{8'h14, 8'h00, 8'h08, 8'h16, 8'hFF, 8'hFF};
    vt[9]  = '{8'h0F, 8'h00, 8'h08, 8'h25, 8'hFF, 8'hFF};
    vt[10] = '{8'h00, 8'hEC, 8'h28, 8'h25, 8'hEB, 8'hFF};
`endif
    for (int k = 0; k < 11; k++) begin
      send(vt[k].x, vt[k].y, vt[k].st);
      cyc();
      cyc();
      chk($sformatf("tbl%0d_x", k),   kx[0], vt[k].ex);
      chk($sformatf("tbl%0d_y", k),   ky[0], vt[k].ey);
      chk($sformatf("tbl%0d_btn", k), kb[0], vt[k].eb);
    end
    rd("tbl_rd_x", 16'hFBDF, 1'b1, vt[10].ex);

    // Back-to-back packets with divisor 2 on dut1, plus overflow axis.
    do_reset();
    send(8'h01, 8'h00, 8'h08);
    cyc();
    send(8'h01, 8'h00, 8'h08);
    cyc();
    chk("b2b_x1", kx[1], 8'h00);
    send(8'h01, 8'h00, 8'h08);
    cyc();
    chk("b2b_x2", kx[1], 8'h01);
    cyc();
    chk("b2b_x3", kx[1], 8'h01);
    chk("b2b_x3_div1", kx[0], 8'h03);
    send(8'hFF, 8'h02, 8'h48);
    cyc();
    cyc();
    chk("ovf_x", kx[1], 8'h01);
    chk("ovf_y", ky[1], 8'h01);
    send(8'h00, 8'h00, 8'h09);
    cyc();
    cyc();
    chk("swap_btn", kb[1], 8'hFE);
    chk("noswap_btn", kb[0], 8'hFD);

    // Disabled: packet ignored, reads ignored; then re-enable.
    do_reset();
    enable = 1'b0;
    send(8'h0A, 8'h00, 8'h08);
    cyc();
    cyc();
    chk("dis_x", kx[0], 8'h00);
    rd("dis_rd", 16'hFBDF, 1'b0, 8'h00);
    enable = 1'b1;
    send(8'h01, 8'h00, 8'h08);
    cyc();
    cyc();
    chk("reen_x", kx[0], 8'h01);
    chk("reen_y", ky[0], 8'h00);

    // Enable drops right after the strobe is sampled: packet still lands.
    send(8'h02, 8'h00, 8'h08);
    cyc();
    enable = 1'b0;
    cyc();
    chk("inflight_x", kx[0], 8'h03);
    enable = 1'b1;

    // Reset one cycle after the strobe discards the packet.
    send(8'h07, 8'h00, 8'h08);
    cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    cyc();
    chk("midrst_x", kx[0], 8'h00);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      enable  = ($urandom_range(0, 7) != 0);
      reset_n = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 2) != 0)
        send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      io_rd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: io_addr = 16'hFBDF;
        1: io_addr = 16'hFFDF;
        2: io_addr = 16'hFADF;
        3: io_addr = {8'($urandom_range(0, 255)), 8'hDF};
        default: io_addr = 16'($urandom_range(0, 65535));
      endcase
      cyc();
    end

    io_rd = 1'b0; enable = 1'b1; reset_n = 1'b1;
    cyc();
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
